// File: rtl/fetch_if_id_stage.sv
// fetch_if_id_stage
//   Instruction-fetch stage plus IF/ID pipeline register for the pipelined
//   LEGv8 core. Holds the PC, presents it to instruction memory, captures
//   {instr, pc} into IF/ID and redirects the PC when the ID-stage decoder
//   resolves a taken branch. The branch offset comes from the instruction
//   sitting in IF/ID.
//
// Parameters
//   ADDR_W     PC / instruction-address width
//   RESET_PC   PC value after reset
//   NOP_INSTR  bubble encoding placed in IF/ID on reset (and on squash)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   stall      hazard-unit hold: freezes PC and IF/ID
//   BrTaken    decoder: branch in ID is taken
//   UncondBr   decoder: 1 = B (imm26), 0 = CBZ/B.LT (imm19)
//   imem_addr  instruction-memory address (combinational copy of PC)
//   imem_instr instruction-memory read data for imem_addr
//   id_instr   IF/ID instruction
//   id_pc      IF/ID PC of id_instr
//   id_valid   IF/ID holds a real fetched instruction (0 = bubble)
//
// Build option
//   BRANCH_FLUSH_EN  when defined, the slot fetched alongside a taken branch
//                    is squashed to NOP_INSTR; when undefined it is kept as
//                    an architectural delay slot.

module fetch_if_id_stage #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h910003FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              BrTaken,
  input  logic              UncondBr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target;
  logic              redirect;

  assign imem_addr = pc;

  // Decoder outputs are only meaningful for a real instruction that is
  // allowed to advance; gating here keeps X on BrTaken from reaching the PC.
  assign redirect = BrTaken & id_valid & ~stall;

  // Word offset sign-extended across the full address width, then scaled
  // to bytes; the sum wraps naturally at ADDR_W bits.
  always_comb begin
    offset = '0;
    if (UncondBr) begin
      offset = {{(ADDR_W-26){id_instr[25]}}, id_instr[25:0]};
    end else begin
      offset = {{(ADDR_W-19){id_instr[23]}}, id_instr[23:5]};
    end
    target = id_pc + {offset[ADDR_W-3:0], 2'b00};
  end

  // Stall has priority over redirect, so a branch held in ID is simply
  // re-evaluated once the stall releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_pc <= pc;
      if (redirect) begin
        pc <= target;
`ifdef BRANCH_FLUSH_EN
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
`else
        id_instr <= imem_instr;
        id_valid <= 1'b1;
`endif
      end else begin
        pc       <= pc + ADDR_W'(4);
        id_instr <= imem_instr;
        id_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// tb_fetch_if_id_stage
//   Self-checking bench for fetch_if_id_stage. A behavioural model predicts
//   the post-edge {imem_addr, id_instr, id_pc, id_valid} each cycle and pushes
//   it to a scoreboard queue; each test pops and compares after the edge, and
//   also checks fixed addresses taken from hand-worked scenarios.
//   Define BRANCH_FLUSH_EN for both bench and RTL to exercise the squash build.

module tb_fetch_if_id_stage;

  localparam logic [31:0] NOP = 32'h910003FF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        BrTaken;
  logic        UncondBr;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_valid;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] idpc;
    logic        valid;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_idpc;
  logic        m_valid;
  int          checks = 0;
  int          errors = 0;

  fetch_if_id_stage #(
    .ADDR_W   (64),
    .RESET_PC (64'h0),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .BrTaken   (BrTaken),
    .UncondBr  (UncondBr),
    .imem_addr (imem_addr),
    .imem_instr(imem_instr),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_valid  (id_valid)
  );

  // Instruction memory: a few branches at fixed addresses, otherwise a
  // non-branch pattern that encodes the address.
  function automatic logic [31:0] instr_at(input logic [63:0] a);
    case (a)
      64'h8:   return 32'h17FFFFFD;
      64'h10:  return 32'h14000004;
      64'h40:  return 32'hB4FFFFE0;
      default: return {11'h458, a[20:0]};
    endcase
  endfunction

  assign imem_instr = instr_at(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict the state after the coming edge (not in reset) and queue it.
  task automatic model_step(input logic s, input logic b, input logic u);
    exp_t        e;
    longint      off;
    logic [63:0] n_pc;
    logic [31:0] n_instr;
    logic [63:0] n_idpc;
    logic        n_valid;
    n_pc = m_pc; n_instr = m_instr; n_idpc = m_idpc; n_valid = m_valid;
    if (s !== 1'b1) begin
      n_idpc  = m_pc;
      n_instr = instr_at(m_pc);
      n_valid = 1'b1;
      if ((b === 1'b1) && m_valid) begin
        if (u) off = longint'($signed(m_instr[25:0]));
        else   off = longint'($signed(m_instr[23:5]));
        n_pc = m_idpc + 64'(off * 4);
`ifdef BRANCH_FLUSH_EN
        n_instr = NOP;
        n_valid = 1'b0;
`endif
      end else begin
        n_pc = m_pc + 64'd4;
      end
    end
    m_pc = n_pc; m_instr = n_instr; m_idpc = n_idpc; m_valid = n_valid;
    e.pc = n_pc; e.instr = n_instr; e.idpc = n_idpc; e.valid = n_valid;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n, input logic s, input logic b);
    reset = 1'b1; stall = s; BrTaken = b; UncondBr = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    m_pc = 64'h0; m_instr = NOP; m_idpc = 64'h0; m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset(2, 1'b1, 1'b1);
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL rst_pc got %h want 0", imem_addr); end
    checks++; if (id_instr !== NOP) begin errors++; $display("[TB] FAIL rst_instr got %h want %h", id_instr, NOP); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", id_valid); end
    checks++; if (id_pc !== 64'h0) begin errors++; $display("[TB] FAIL rst_idpc got %h want 0", id_pc); end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      BrTaken = (i == 0) ? 1'bx : 1'b0; UncondBr = 1'bx;
      model_step(stall, BrTaken, UncondBr); tick(); e = sb.pop_front();
      checks++;
      if ({imem_addr, id_instr, id_pc, id_valid} !== e) begin errors++;
        $display("[TB] FAIL reset_seq[%0d] got %h/%h/%h/%b want %h/%h/%h/%b", i, imem_addr, id_instr, id_pc, id_valid, e.pc, e.instr, e.idpc, e.valid); end
      checks++;
      if (id_pc !== 64'(i * 4) || id_valid !== 1'b1) begin errors++;
        $display("[TB] FAIL line_idpc[%0d] got %h/%b want %h/1", i, id_pc, id_valid, 64'(i * 4)); end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      stall = (i >= 2 && i < 5); BrTaken = stall ? 1'bx : 1'b0; UncondBr = 1'b0;
      model_step(stall, BrTaken, UncondBr); tick(); e = sb.pop_front();
      checks++;
      if ({imem_addr, id_instr, id_pc, id_valid} !== e) begin errors++;
        $display("[TB] FAIL stall_seq[%0d] got %h/%h/%h/%b want %h/%h/%h/%b", i, imem_addr, id_instr, id_pc, id_valid, e.pc, e.instr, e.idpc, e.valid); end
      if (i >= 2 && i < 5) begin
        checks++;
        if (imem_addr !== 64'h8 || id_pc !== 64'h4 || id_instr !== 32'h8B000004) begin errors++;
          $display("[TB] FAIL stall_hold[%0d] got %h/%h/%h want 8/4/8b000004", i, imem_addr, id_pc, id_instr); end
      end
    end
    checks++;
    if (imem_addr !== 64'hC || id_pc !== 64'h8) begin errors++;
      $display("[TB] FAIL stall_resume got %h/%h want c/8", imem_addr, id_pc); end
    stall = 1'b0;
  endtask

  task automatic test_uncond_branch();
    exp_t e;
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      BrTaken = (i == 5); UncondBr = 1'b1;
      model_step(stall, BrTaken, UncondBr); tick(); e = sb.pop_front();
      checks++;
      if ({imem_addr, id_instr, id_pc, id_valid} !== e) begin errors++;
        $display("[TB] FAIL b_seq[%0d] got %h/%h/%h/%b want %h/%h/%h/%b", i, imem_addr, id_instr, id_pc, id_valid, e.pc, e.instr, e.idpc, e.valid); end
      if (i == 5) begin
        checks++;
        if (imem_addr !== 64'h20) begin errors++; $display("[TB] FAIL b_target got %h want 20", imem_addr); end
        checks++;
`ifdef BRANCH_FLUSH_EN
        if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 64'h14) begin errors++;
          $display("[TB] FAIL b_slot got %h/%h/%b want %h/14/0", id_instr, id_pc, id_valid, NOP); end
`else
        if (id_valid !== 1'b1 || id_instr !== 32'h8B000014 || id_pc !== 64'h14) begin errors++;
          $display("[TB] FAIL b_slot got %h/%h/%b want 8b000014/14/1", id_instr, id_pc, id_valid); end
`endif
      end
    end
    checks++;
    if (id_pc !== 64'h20 || id_valid !== 1'b1) begin errors++;
      $display("[TB] FAIL b_after got %h/%b want 20/1", id_pc, id_valid); end
  endtask

  task automatic test_cond_branch();
    exp_t e;
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      BrTaken = (i == 17); UncondBr = 1'b0;
      model_step(stall, BrTaken, UncondBr); tick(); e = sb.pop_front();
      checks++;
      if ({imem_addr, id_instr, id_pc, id_valid} !== e) begin errors++;
        $display("[TB] FAIL cbz_seq[%0d] got %h/%h/%h/%b want %h/%h/%h/%b", i, imem_addr, id_instr, id_pc, id_valid, e.pc, e.instr, e.idpc, e.valid); end
      if (i == 17) begin
        checks++;
        if (imem_addr !== 64'h3C) begin errors++; $display("[TB] FAIL cbz_target got %h want 3c", imem_addr); end
      end
    end
    checks++;
    if (id_pc !== 64'h3C || id_instr !== 32'h8B00003C) begin errors++;
      $display("[TB] FAIL cbz_after got %h/%h want 3c/8b00003c", id_pc, id_instr); end
  endtask

  task automatic test_stall_branch();
    exp_t e;
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      stall = (i == 5 || i == 6); BrTaken = (i >= 5 && i <= 7); UncondBr = 1'b1;
      model_step(stall, BrTaken, UncondBr); tick(); e = sb.pop_front();
      checks++;
      if ({imem_addr, id_instr, id_pc, id_valid} !== e) begin errors++;
        $display("[TB] FAIL stbr_seq[%0d] got %h/%h/%h/%b want %h/%h/%h/%b", i, imem_addr, id_instr, id_pc, id_valid, e.pc, e.instr, e.idpc, e.valid); end
      if (i == 5 || i == 6) begin
        checks++;
        if (imem_addr !== 64'h14 || id_pc !== 64'h10) begin errors++;
          $display("[TB] FAIL stbr_hold[%0d] got %h/%h want 14/10", i, imem_addr, id_pc); end
      end
      if (i == 7) begin
        checks++;
        if (imem_addr !== 64'h20) begin errors++; $display("[TB] FAIL stbr_target got %h want 20", imem_addr); end
      end
    end
    checks++;
    if (imem_addr !== 64'h24 || id_pc !== 64'h20) begin errors++;
      $display("[TB] FAIL stbr_once got %h/%h want 24/20", imem_addr, id_pc); end
    stall = 1'b0;
  endtask

  task automatic test_wrap_reset();
    exp_t e;
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      BrTaken = (i == 3); UncondBr = 1'b1;
      model_step(stall, BrTaken, UncondBr); tick(); e = sb.pop_front();
      checks++;
      if ({imem_addr, id_instr, id_pc, id_valid} !== e) begin errors++;
        $display("[TB] FAIL wrap_seq[%0d] got %h/%h/%h/%b want %h/%h/%h/%b", i, imem_addr, id_instr, id_pc, id_valid, e.pc, e.instr, e.idpc, e.valid); end
      if (i == 3) begin
        checks++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL neg_target got %h want fffffffffffffffc", imem_addr); end
      end
      if (i == 4) begin
        checks++;
        if (imem_addr !== 64'h0 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++;
          $display("[TB] FAIL wrap got %h/%h want 0/fffffffffffffffc", imem_addr, id_pc); end
      end
    end
    checks++;
    if (id_instr !== 32'h17FFFFFD || id_valid !== 1'b1) begin errors++;
      $display("[TB] FAIL wrap_br_in_id got %h/%b want 17fffffd/1", id_instr, id_valid); end
    reset = 1'b1; stall = 1'b0; BrTaken = 1'b1; UncondBr = 1'b1;
    tick();
    checks++;
    if (imem_addr !== 64'h0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 64'h0) begin errors++;
      $display("[TB] FAIL mid_reset got %h/%h/%h/%b want 0/%h/0/0", imem_addr, id_instr, id_pc, id_valid, NOP); end
    reset = 1'b0; BrTaken = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
    test_reset();
    test_stall();
    test_uncond_branch();
    test_cond_branch();
    test_stall_branch();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
